// File: rtl/basys_top.sv
// Demo top for the Basys 4-digit seven-segment display. It shows a 16-bit
// counter as hex digits; the counter advances once per divided-clock period.
module basys_top #(
  parameter int DIV_HALF   = 4,
  parameter int SCAN_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       resetClk,
  output logic [6:0] seg,
  output logic       clkDiv,
  output logic [3:0] an
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int SW = SCAN_SHIFT + 2;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

  logic [DW-1:0] div_cnt_reg, div_cnt_next;
  logic          clkdiv_reg, clkdiv_next;
  logic          tick_reg, tick_next;
  logic          div_wrap;

  logic [15:0]   value_reg, value_next;
  logic [SW-1:0] scan_reg, scan_next;
  logic [1:0]    sel;
  logic [3:0]    nib [4];
  logic [3:0]    digit;

  // Divider domain: cleared only by resetClk.
  always_ff @(posedge clk or negedge resetClk) begin
    if (!resetClk) begin
      div_cnt_reg <= '0;
      clkdiv_reg  <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      clkdiv_reg  <= clkdiv_next;
      tick_reg    <= tick_next;
    end
  end

  always_comb begin
    div_wrap     = (div_cnt_reg == DIV_LAST);
    div_cnt_next = div_wrap ? '0 : div_cnt_reg + DW'(1);
    clkdiv_next  = clkdiv_reg ^ div_wrap;
    // Pulse only on the toggle that takes clkDiv from 0 to 1.
    tick_next    = div_wrap & ~clkdiv_reg;
  end

  // Value and scan: cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_reg <= 16'h0000;
      scan_reg  <= '0;
    end else begin
      value_reg <= value_next;
      scan_reg  <= scan_next;
    end
  end

  always_comb begin
    value_next = tick_reg ? value_reg + 16'd1 : value_reg;
    scan_next  = scan_reg + SW'(1);
  end

  assign sel = scan_reg[SW-1 -: 2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign nib[gi] = value_reg[4*gi +: 4];
      assign an[gi]  = (sel != 2'(gi));
    end
  endgenerate

  assign digit  = nib[sel];
  assign clkDiv = clkdiv_reg;

  always_comb begin
    seg = 7'b1000000;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1000000;
    endcase
  end

endmodule

// File: tb/tb_basys_top.sv
// Randomized bench for basys_top. The reference model counts clk edges since
// each reset release and derives clkDiv, the counter value and the scanned digit arithmetically.
module tb_basys_top;

  localparam int D = 4;
  localparam int S = 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       resetClk = 1'b1;
  logic [6:0] seg;
  logic       clkDiv;
  logic [3:0] an;

  basys_top #(.DIV_HALF(D), .SCAN_SHIFT(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .resetClk (resetClk),
    .seg      (seg),
    .clkDiv   (clkDiv),
    .an       (an)
  );

  always #5 clk = ~clk;

  // Model state: edges since resetClk release, edges since reset release, counter value.
  int          n_div    = 0;
  int          n_scan   = 0;
  int unsigned mval     = 0;
  int          checks   = 0;
  int          fails    = 0;
  int          seg_runs = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int         sel;
    logic [3:0] an_exp;
    logic [3:0] nib_exp;
    sel     = (n_scan >> S) % 4;
    an_exp  = 4'b1111;
    an_exp[sel] = 1'b0;
    nib_exp = 4'((mval >> (4 * sel)) & 15);
    check_eq("clkDiv", 16'(clkDiv), 16'((n_div / D) % 2));
    check_eq("an", 16'(an), 16'(an_exp));
    check_eq("seg", 16'(seg), 16'(hex_tbl[nib_exp]));
  endtask

  // One clk edge: clkDiv rises at edges D, 3D, ...; the counter bumps one edge later.
  task automatic step();
    @(posedge clk);
    if (resetClk) n_div++;
    if (reset) begin
      if (resetClk && n_div > 0 && (n_div % (2 * D)) == ((D + 1) % (2 * D)))
        mval = (mval + 1) & 32'hFFFF;
      n_scan++;
    end
    #1;
    check_outputs();
  endtask

  // Reset levels change mid-cycle; assertion must show up without a clk edge.
  task automatic set_rst(input logic r, input logic rc);
    @(negedge clk);
    reset    = r;
    resetClk = rc;
    if (!r) begin
      mval   = 0;
      n_scan = 0;
    end
    if (!rc) n_div = 0;
    #1;
    check_outputs();
  endtask

  initial begin
    #3;
    reset    = 1'b0;
    resetClk = 1'b0;
    #1;
    check_outputs();
    repeat (5) step();
    $display("both resets held: value=%h clkDiv=%0d", mval, clkDiv);

    set_rst(1'b0, 1'b1);
    repeat (24) step();
    $display("divider released, value held: value=%h", mval);

    set_rst(1'b1, 1'b1);
    repeat (60) step();
    $display("free run: value=%h", mval);

    for (int i = 0; i < 40; i++) begin
      logic r;
      logic rc;
      int   len;
      r   = ($urandom_range(0, 5) != 0);
      rc  = ($urandom_range(0, 5) != 0);
      len = $urandom_range(1, 30);
      set_rst(r, rc);
      repeat (len) step();
      seg_runs++;
      $display("segment %0d: reset=%0b resetClk=%0b cycles=%0d value=%h", i, r, rc, len, mval);
    end

    set_rst(1'b1, 1'b1);
    repeat (3) step();

    @(negedge clk);
    force dut.value_reg = 16'hFFF0;
    #1;
    release dut.value_reg;
    mval = 32'hFFF0;
    check_outputs();
    repeat (200) step();
    $display("wrap run: value=%h", mval);

    set_rst(1'b0, 1'b1);
    repeat (10) step();
    set_rst(1'b1, 1'b1);
    repeat (40) step();
    set_rst(1'b1, 1'b0);
    repeat (10) step();
    set_rst(1'b1, 1'b1);
    repeat (30) step();
    $display("reset mid-run done: value=%h segments=%0d", mval, seg_runs);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
